toggle_line_deframer: RTL and testbench
=======================================

// Module: toggle_line_deframer
// PURPOSE
//   Receive end of a transition-signalled serial line. Upstream, a T flip-flop encodes the stream:
//   the line toggles when t=1 and holds when t=0. This block recovers t by comparing each sample
//   with the previous one and deframes it into DATA_W-bit words. Words are buffered in a small
//   FIFO and drained through a valid/ready port.
// PARAMETERS
//   DATA_W      8   payload bits per frame
//   FIFO_DEPTH  4   output FIFO entries; power of 2, >= 2
//   Q_INIT      0   assumed line level after reset (matches encoder reset level)
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   q_in       in   1       toggle-encoded line, synchronous to clk
//   in_valid   in   1       q_in holds a new symbol this cycle
//   out_data   out  DATA_W  FIFO head word
//   out_valid  out  1       FIFO not empty
//   out_ready  in   1       consumer accepts out_data this cycle
//   frame_err  out  1       1-cycle pulse: bad stop bit
//   overflow   out  1       sticky: a word was dropped because the FIFO was full
// BEHAVIOUR
//   Reset
//     - Async on rst_n=0: q_prev=Q_INIT, FSM=IDLE, FIFO empty.
//     - All outputs 0.
//     - A partial frame is discarded.
//   Decode
//     - Only when in_valid=1: t_bit = q_in ^ q_prev, then q_prev <= q_in.
//     - When in_valid=0, all state holds.
//   Frame (decoded bits, one per symbol)
//     - Start t=1; then DATA_W data bits, LSB first; [parity]; stop t=0.
//   FSM (advances only on in_valid)
//     - IDLE: t_bit=1 -> DATA, bit_cnt=0. t_bit=0 -> stay.
//     - DATA: shift t_bit into bit[bit_cnt]. At bit_cnt=DATA_W-1 -> PARITY if enabled, else STOP.
//     - PARITY: capture parity bit -> STOP.
//     - STOP: t_bit=0 -> push word (if checks pass) -> IDLE.
//             t_bit=1 -> frame_err pulse, discard word -> IDLE.
//       The erroneous 1 is NOT taken as a new start bit.
//   FIFO
//     - Push happens on the STOP symbol cycle; the word shows at out_valid/out_data on the next cycle.
//     - Pop when out_valid & out_ready. out_data is the head word and stays stable while
//       out_valid=1 and out_ready=0.
//     - Push while full: accepted only if a pop occurs in the same cycle. Otherwise the word is
//       dropped and overflow is set until reset.
//     - Push and pop on an empty FIFO: no bypass; the word appears the next cycle.
//     - Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
//     - full: MSBs differ and low bits are equal. empty: pointers are equal.
//   Error pulses are registered and last exactly one cycle. Errors never block later frames.
// CONFIGURATION
//   TLD_PARITY_EN defined
//     - PARITY state exists; the frame carries an even-parity bit after the data.
//     - Extra output port par_err (1 bit, reset 0). It pulses for 1 cycle on mismatch, on the
//       STOP cycle, and the word is discarded.
//     - If the stop bit is also bad, only frame_err pulses.
//   TLD_PARITY_EN undefined
//     - No PARITY state and no par_err port.
//     - Frame length is DATA_W+2 symbols.
// TESTING (DATA_W=8, FIFO_DEPTH=4, Q_INIT=0; the bench drives q_in through a T flip-flop model
// fed with frame bits; parity off unless noted)
//   1. t = 1, 1,0,1,0,0,1,0,1, 0 on consecutive in_valid cycles -> one cycle after the stop
//      symbol, out_valid=1 and out_data=8'hA5. out_ready=1 -> out_valid=0 next cycle.
//   2. Frame 8'h3C with in_valid low every other cycle -> same result as a gapless frame.
//      State and q_prev hold during gaps.
//   3. Five frames 01,02,03,04,05 with out_ready=0 -> FIFO holds 01..04 and overflow=1.
//      Then drain with out_ready=1 -> 01,02,03,04 out; out_valid=0 afterwards.
//   4. Frame 8'h55 with stop t=1 -> frame_err is a 1-cycle pulse and nothing is pushed.
//      A following valid 8'h12 frame is received correctly.
//   5. rst_n pulsed low after 4 data bits of 8'hFF, then frame 8'h81 -> all outputs are 0
//      during reset; only 8'h81 is received.
//   6. TLD_PARITY_EN: 8'h07 with parity 1 -> received. 8'h07 with parity 0 -> par_err pulse,
//      no push.

Source files
------------

// File: rtl/toggle_line_deframer.sv
// Deframer for a T-flip-flop encoded serial line: recovers t from line transitions, deframes
// DATA_W-bit words and buffers them in a FIFO. Define TLD_PARITY_EN for even parity + par_err.
module toggle_line_deframer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          Q_INIT     = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              q_in,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
`ifdef TLD_PARITY_EN
  output logic              par_err,
`endif
  output logic              overflow
);

  localparam int unsigned CntW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

`ifdef TLD_PARITY_EN
  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StData, StStop} state_e;
`endif

  state_e            state_q, state_d;
  logic              q_prev_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic              frame_err_q, frame_err_d;
  logic              overflow_q;
  logic              t_bit, push, par_bad;
`ifdef TLD_PARITY_EN
  logic              par_q;
  logic              par_err_q, par_err_d;
`endif

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic              full, empty, pop, do_push;

  assign t_bit = q_in ^ q_prev_q;

`ifdef TLD_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_bad = (^shreg_q) ^ par_q;
`else
  assign par_bad = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (in_valid) begin
      unique case (state_q)
        StIdle: if (t_bit) state_d = StData;
        StData: begin
          if (bit_cnt_q == LastCnt) begin
`ifdef TLD_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
`ifdef TLD_PARITY_EN
        StParity: state_d = StStop;
`endif
        StStop:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Output logic: a bad stop bit masks any parity verdict
  always_comb begin
    push        = 1'b0;
    frame_err_d = 1'b0;
`ifdef TLD_PARITY_EN
    par_err_d   = 1'b0;
`endif
    if (in_valid && state_q == StStop) begin
      if (t_bit) begin
        frame_err_d = 1'b1;
      end else if (par_bad) begin
`ifdef TLD_PARITY_EN
        par_err_d = 1'b1;
`endif
      end else begin
        push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_prev_q    <= Q_INIT;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef TLD_PARITY_EN
      par_q       <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      frame_err_q <= frame_err_d;
`ifdef TLD_PARITY_EN
      par_err_q   <= par_err_d;
`endif
      if (in_valid) begin
        q_prev_q <= q_in;
        if (state_q == StIdle) begin
          bit_cnt_q <= '0;
        end else if (state_q == StData) begin
          shreg_q[bit_cnt_q] <= t_bit;
          bit_cnt_q          <= bit_cnt_q + CntW'(1);
        end
`ifdef TLD_PARITY_EN
        if (state_q == StParity) par_q <= t_bit;
`endif
      end
    end
  end

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]);
  assign pop     = !empty && out_ready;
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[PtrW-2:0]] <= shreg_q;
        wr_ptr_q                  <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !do_push) overflow_q <= 1'b1;
    end
  end

  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q[PtrW-2:0]];
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
`ifdef TLD_PARITY_EN
  assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_toggle_line_deframer.sv
// Scoreboard bench for toggle_line_deframer: frames are T-encoded by a line model, expected
// words are queued on send and compared when the DUT pops them.
module tb_toggle_line_deframer;

  localparam int unsigned DataW = 8;
  localparam int unsigned Depth = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             q_in = 1'b0;
  logic             in_valid = 1'b0;
  logic [DataW-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             frame_err;
  logic             overflow;
`ifdef TLD_PARITY_EN
  logic             par_err;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [DataW-1:0] exp_q[$];
  logic             exp_ovf = 1'b0;
  logic             line = 1'b0;

  toggle_line_deframer #(.DATA_W(DataW), .FIFO_DEPTH(Depth), .Q_INIT(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .q_in      (q_in),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
`ifdef TLD_PARITY_EN
    .par_err   (par_err),
`endif
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A pop happens at the next rising edge whenever valid & ready are seen here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_word", {24'd0, out_data}, 32'hFFFF_FFFF);
      else check("word", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One encoded symbol; with gap, an idle cycle carrying junk on q_in follows.
  task automatic send_sym(input bit t, input bit gap);
    cycle();
    line     = line ^ t;
    q_in     = line;
    in_valid = 1'b1;
    if (gap) begin
      cycle();
      in_valid = 1'b0;
      q_in     = ~line;
    end
  endtask

  // Returns at posedge+1 of the edge that consumed the stop symbol.
  task automatic send_frame(input logic [DataW-1:0] data, input bit stop_t, input bit par_flip,
                            input bit gap);
    bit good;
    send_sym(1'b1, gap);
    for (int i = 0; i < DataW; i++) send_sym(data[i], gap);
`ifdef TLD_PARITY_EN
    send_sym((^data) ^ par_flip, gap);
    good = !stop_t && !par_flip;
`else
    good = !stop_t;
`endif
    send_sym(stop_t, gap);
    if (good) begin
      if (exp_q.size() < Depth) exp_q.push_back(data);
      else exp_ovf = 1'b1;
    end
    if (!gap) begin
      cycle();
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      cycle();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overflow", overflow, 0);
    rst_n = 1'b1;

    // 1: A5 gapless, visible the cycle after stop, popped with ready
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 8'hA5);
    out_ready = 1'b1;
    cycle();
    check("t1_valid_after_pop", out_valid, 0);
    check("t1_drained", exp_q.size(), 0);

    // 2: 3C with gaps
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    check("t2_valid", out_valid, 1);
    check("t2_data", out_data, 8'h3C);
    out_ready = 1'b1;
    wait_drain("t2_drained");

    // 3: overflow with consumer stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
    check("t3_overflow", overflow, exp_ovf);
    check("t3_overflow_set", overflow, 1);
    check("t3_head", out_data, 8'h01);
    check("t3_queued", exp_q.size(), 4);
    out_ready = 1'b1;
    wait_drain("t3_drained");
    cycle();
    check("t3_valid_empty", out_valid, 0);

    // 4: bad stop bit, then a good frame
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    check("t4_frame_err", frame_err, 1);
    check("t4_no_push", out_valid, 0);
    cycle();
    check("t4_pulse_end", frame_err, 0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0);
    check("t4_no_err", frame_err, 0);
    wait_drain("t4_drained");

    // 5: reset mid-frame
    send_sym(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_sym(1'b1, 1'b0);
    cycle();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    line     = 1'b0;
    exp_ovf  = 1'b0;
    q_in     = 1'b0;
    #2;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_data", out_data, 0);
    check("t5_rst_frame_err", frame_err, 0);
    check("t5_rst_overflow", overflow, 0);
    cycle();
    rst_n = 1'b1;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    check("t5_head", out_data, 8'h81);
    wait_drain("t5_drained");
    cycle();
    check("t5_empty", out_valid, 0);

`ifdef TLD_PARITY_EN
    // 6: parity good, then parity bad
    send_frame(8'h07, 1'b0, 1'b0, 1'b0);
    check("t6_par_ok", par_err, 0);
    wait_drain("t6_drained");
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    check("t6_par_err", par_err, 1);
    check("t6_par_frame_err", frame_err, 0);
    check("t6_no_push", out_valid, 0);
    cycle();
    check("t6_pulse_end", par_err, 0);
`endif

    check("final_overflow", overflow, exp_ovf);
    check("final_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
